// File: rtl/stoptimer_pkg.sv
// -----------------------------------------------------------------------------
// stoptimer_pkg
// Shared types, widths and helpers for the stoptimer display path:
//   - conversion FSM state enum (IDLE/SHIFT/DONE)
//   - packed BCD payload {hundreds, tens, ones}
//   - seven-segment encoder and the shift-add-3 nibble adjust
// -----------------------------------------------------------------------------
package stoptimer_pkg;

  localparam int unsigned BIN_W      = 8;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned BCD_W      = NUM_DIGITS * NIBBLE_W;
  localparam int unsigned SEG_W      = 7;
  // One shift iteration per input bit; 3 bits count iterations 0..7.
  localparam int unsigned ITER_W     = 3;
  localparam int unsigned DIG_IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  typedef struct packed {
    logic [NIBBLE_W-1:0] hundreds;
    logic [NIBBLE_W-1:0] tens;
    logic [NIBBLE_W-1:0] ones;
  } bcd_t;

  // Segment pattern {g,f,e,d,c,b,a}, active-high; non-decimal nibbles go dark.
  function automatic logic [SEG_W-1:0] seg_encode(input logic [NIBBLE_W-1:0] nibble);
    logic [SEG_W-1:0] pattern;
    pattern = 7'b0000000;
    case (nibble)
      4'd0:    pattern = 7'b0111111;
      4'd1:    pattern = 7'b0000110;
      4'd2:    pattern = 7'b1011011;
      4'd3:    pattern = 7'b1001111;
      4'd4:    pattern = 7'b1100110;
      4'd5:    pattern = 7'b1101101;
      4'd6:    pattern = 7'b1111101;
      4'd7:    pattern = 7'b0000111;
      4'd8:    pattern = 7'b1111111;
      4'd9:    pattern = 7'b1101111;
      default: pattern = 7'b0000000;
    endcase
    return pattern;
  endfunction

  // Double-dabble correction: a nibble >= 5 would exceed 9 after doubling.
  function automatic logic [NIBBLE_W-1:0] add3(input logic [NIBBLE_W-1:0] nibble);
    logic [NIBBLE_W-1:0] res;
    res = nibble;
    if (nibble >= 4'd5) begin
      res = nibble + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3).
// A new conversion starts whenever the input differs from the last converted
// value; the result appears 9 edges after capture with a one-cycle strobe.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bin        binary input, 0..255
//   bcd        {hundreds, tens, ones} of the last completed conversion
//   bcd_valid  one-cycle pulse coincident with a bcd update
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import stoptimer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             bcd_valid
);

  conv_state_e state_q, state_d;

  logic [BIN_W-1:0]  shift_q, shift_d;   // binary bits still to be shifted in
  logic [BIN_W-1:0]  cap_q,   cap_d;     // value being converted
  logic [BIN_W-1:0]  last_q,  last_d;    // value of the last completed conversion
  logic [ITER_W-1:0] iter_q,  iter_d;
  bcd_t              acc_q,   acc_d;
  bcd_t              bcd_q,   bcd_d;
  logic              valid_q, valid_d;

  logic start_c;
  logic last_iter_c;
  bcd_t adj_c;

  assign start_c     = (bin != last_q);
  assign last_iter_c = (iter_q == ITER_W'(BIN_W - 1));

  // Add-3 correction applied to every accumulator digit before each shift.
  always_comb begin
    adj_c          = acc_q;
    adj_c.hundreds = add3(acc_q.hundreds);
    adj_c.tens     = add3(acc_q.tens);
    adj_c.ones     = add3(acc_q.ones);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; input changes are only observed in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_c) state_d = SHIFT;
      SHIFT:   if (last_iter_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output next values per state.
  always_comb begin
    shift_d = shift_q;
    cap_d   = cap_q;
    last_d  = last_q;
    iter_d  = iter_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          shift_d = bin;
          cap_d   = bin;
          acc_d   = '0;
          iter_d  = '0;
        end
      end
      SHIFT: begin
        {acc_d, shift_d} = {adj_c, shift_q} << 1;
        iter_d           = iter_q + ITER_W'(1);
      end
      DONE: begin
        // Only completed results reach the visible register.
        bcd_d   = acc_q;
        last_d  = cap_q;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cap_q   <= '0;
      last_q  <= '0;
      iter_q  <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cap_q   <= cap_d;
      last_q  <= last_d;
      iter_q  <= iter_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = valid_q;

endmodule

// File: rtl/stoptimer_display.sv
// -----------------------------------------------------------------------------
// stoptimer_display
// Converts the stoptimer elapsed count to BCD and scans it onto a 3-digit
// multiplexed 7-segment display with optional leading-zero blanking.
//
// Parameters:
//   SCAN_DIV       clocks each digit stays enabled (>= 2)
//   BLANK_LEADING  1: blank leading zeros in hundreds/tens; 0: show all digits
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   elapsed_time  binary count 0..255
//   bcd           {hundreds, tens, ones} of the last completed conversion
//   bcd_valid     one-cycle pulse when bcd updates
//   seg           segments {g,f,e,d,c,b,a}, active-high
//   an            one-hot digit enable: an[0]=ones, an[1]=tens, an[2]=hundreds
// -----------------------------------------------------------------------------
module stoptimer_display
  import stoptimer_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      elapsed_time,
  output logic [BCD_W-1:0]      bcd,
  output logic                  bcd_valid,
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [DIG_IDX_W-1:0] DIG_ONES = DIG_IDX_W'(0);
  localparam logic [DIG_IDX_W-1:0] DIG_TENS = DIG_IDX_W'(1);
  localparam logic [DIG_IDX_W-1:0] DIG_HUND = DIG_IDX_W'(2);

  logic [BCD_W-1:0]     bcd_w;
  logic [SCAN_W-1:0]    scan_q, scan_d;
  logic [DIG_IDX_W-1:0] idx_q,  idx_d;
  logic                 scan_wrap_c;
  bcd_t                 disp_c;
  logic [NIBBLE_W-1:0]  nibble_c;
  logic                 blank_c;

  bin2bcd_seq u_bin2bcd (
    .clk       (clk),
    .rst_n     (rst_n),
    .bin       (elapsed_time),
    .bcd       (bcd_w),
    .bcd_valid (bcd_valid)
  );

  assign bcd    = bcd_w;
  assign disp_c = bcd_w;

  // Scan counter and digit index; the index advances on each counter wrap.
  assign scan_wrap_c = (scan_q == SCAN_W'(SCAN_DIV - 1));

  always_comb begin
    scan_d = scan_q + SCAN_W'(1);
    idx_d  = idx_q;
    if (scan_wrap_c) begin
      scan_d = '0;
      idx_d  = (idx_q == DIG_HUND) ? DIG_ONES : idx_q + DIG_IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
      idx_q  <= DIG_ONES;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
    end
  end

  // One-hot digit enable decoded from the registered index.
  always_comb begin
    an = 3'b001;
    case (idx_q)
      DIG_ONES: an = 3'b001;
      DIG_TENS: an = 3'b010;
      DIG_HUND: an = 3'b100;
      default:  an = 3'b001;
    endcase
  end

  // Digit select and leading-zero blanking; a blanked digit keeps its enable.
  always_comb begin
    nibble_c = disp_c.ones;
    blank_c  = 1'b0;
    case (idx_q)
      DIG_TENS: begin
        nibble_c = disp_c.tens;
        blank_c  = BLANK_LEADING && (disp_c.hundreds == 4'd0) && (disp_c.tens == 4'd0);
      end
      DIG_HUND: begin
        nibble_c = disp_c.hundreds;
        blank_c  = BLANK_LEADING && (disp_c.hundreds == 4'd0);
      end
      default: begin
        nibble_c = disp_c.ones;
        blank_c  = 1'b0;
      end
    endcase
  end

  assign seg = blank_c ? '0 : seg_encode(nibble_c);

endmodule

// File: tb/tb_stoptimer_display.sv
// -----------------------------------------------------------------------------
// tb_stoptimer_display
// Two instances (blanking on / off) share clock, reset and input. A decimal
// reference model predicts bcd, bcd_valid, an and seg every cycle; a vector
// table and a few hand-written sequences check fixed expectations.
// -----------------------------------------------------------------------------
module tb_stoptimer_display;

  localparam int unsigned SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] elapsed_time = 8'd0;

  logic [11:0] bcd, bcd_nb;
  logic        bcd_valid, bcd_valid_nb;
  logic [6:0]  seg, seg_nb;
  logic [2:0]  an, an_nb;

  stoptimer_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .elapsed_time(elapsed_time),
    .bcd(bcd), .bcd_valid(bcd_valid), .seg(seg), .an(an)
  );

  stoptimer_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .elapsed_time(elapsed_time),
    .bcd(bcd_nb), .bcd_valid(bcd_valid_nb), .seg(seg_nb), .an(an_nb)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  // Reference model state (decimal values and cycle counts).
  int m_last  = 0;
  int m_busy  = 0;
  int m_cap   = 0;
  int m_val   = 0;
  bit m_valid = 1'b0;
  int m_scan  = 0;
  int m_idx   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = 0; m_busy = 0; m_cap = 0; m_val = 0;
      m_valid = 1'b0; m_scan = 0; m_idx = 0;
    end else begin
      m_valid = 1'b0;
      if (m_busy == 0) begin
        if (int'(elapsed_time) != m_last) begin
          m_cap  = int'(elapsed_time);
          m_busy = 9;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_val   = m_cap;
          m_last  = m_cap;
          m_valid = 1'b1;
        end
      end
      if (m_scan == int'(SCAN_DIV) - 1) begin
        m_scan = 0;
        m_idx  = (m_idx + 1) % 3;
      end else begin
        m_scan++;
      end
    end
  end

  function automatic logic [11:0] to_bcd(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int idx, input bit blank);
    int d;
    d = (idx == 0) ? v % 10 : (idx == 1) ? (v / 10) % 10 : v / 100;
    if (blank && ((idx == 2 && v < 100) || (idx == 1 && v < 10))) return 7'b0000000;
    return SEG_TAB[d];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("model_bcd",       32'(bcd),          32'(to_bcd(m_val)));
    chk("model_valid",     32'(bcd_valid),    32'(m_valid));
    chk("model_an",        32'(an),           32'(1 << m_idx));
    chk("model_seg",       32'(seg),          32'(exp_seg(m_val, m_idx, 1'b1)));
    chk("model_bcd_nb",    32'(bcd_nb),       32'(to_bcd(m_val)));
    chk("model_valid_nb",  32'(bcd_valid_nb), 32'(m_valid));
    chk("model_an_nb",     32'(an_nb),        32'(1 << m_idx));
    chk("model_seg_nb",    32'(seg_nb),       32'(exp_seg(m_val, m_idx, 1'b0)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  // Steps until a bcd_valid pulse (bounded); lat = steps taken, 0 on timeout.
  task automatic wait_pulse(output int lat, output bit found);
    lat = 0;
    found = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (bcd_valid) begin
        lat = i;
        found = 1'b1;
        break;
      end
    end
  endtask

  // One full scan round: record the segment pattern shown for each digit.
  task automatic collect(input bit nb, output logic [6:0] s0, output logic [6:0] s1,
                         output logic [6:0] s2, output int pulses);
    logic [2:0] a;
    logic [6:0] sg;
    s0 = 'x; s1 = 'x; s2 = 'x;
    pulses = 0;
    for (int i = 0; i < 3 * int'(SCAN_DIV); i++) begin
      step();
      a  = nb ? an_nb  : an;
      sg = nb ? seg_nb : seg;
      case (a)
        3'b001:  s0 = sg;
        3'b010:  s1 = sg;
        3'b100:  s2 = sg;
        default: ;
      endcase
      if (nb ? bcd_valid_nb : bcd_valid) pulses++;
    end
  endtask

  typedef struct {
    logic [7:0]  val;
    logic [11:0] bcd;
    logic [6:0]  s_one;
    logic [6:0]  s_ten;
    logic [6:0]  s_hun;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat;
    bit found;
    int pulses;
    logic [6:0] s0, s1, s2;

    vecs[0] = '{8'd255, 12'h255, 7'b1101101, 7'b1101101, 7'b1011011};
    vecs[1] = '{8'd7,   12'h007, 7'b0000111, 7'b0000000, 7'b0000000};
    vecs[2] = '{8'd100, 12'h100, 7'b0111111, 7'b0111111, 7'b0000110};
    vecs[3] = '{8'd42,  12'h042, 7'b1011011, 7'b1100110, 7'b0000000};
    vecs[4] = '{8'd5,   12'h005, 7'b1101101, 7'b0000000, 7'b0000000};
    vecs[5] = '{8'd208, 12'h208, 7'b1111111, 7'b0111111, 7'b1011011};
    vecs[6] = '{8'd90,  12'h090, 7'b0111111, 7'b1101111, 7'b0000000};
    vecs[7] = '{8'd0,   12'h000, 7'b0111111, 7'b0000000, 7'b0000000};

    // Reset with input 0.
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_bcd",   32'(bcd),       32'h000);
    chk("rst_valid", 32'(bcd_valid), 32'h0);
    chk("rst_an",    32'(an),        32'b001);
    chk("rst_seg",   32'(seg),       32'b0111111);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bcd_valid) pulses++;
    end
    chk("idle_no_pulse", 32'(pulses), 32'd0);

    // Vector table: latency, value, per-digit segments, single pulse.
    for (int v = 0; v < 8; v++) begin
      elapsed_time = vecs[v].val;
      wait_pulse(lat, found);
      chk("vec_latency", 32'(lat), 32'd10);
      chk("vec_bcd", 32'(bcd), 32'(vecs[v].bcd));
      collect(1'b0, s0, s1, s2, pulses);
      chk("vec_seg_ones", 32'(s0), 32'(vecs[v].s_one));
      chk("vec_seg_tens", 32'(s1), 32'(vecs[v].s_ten));
      chk("vec_seg_hund", 32'(s2), 32'(vecs[v].s_hun));
      chk("vec_single_pulse", 32'(pulses), 32'd0);
    end

    // Input change mid-SHIFT: 100 completes first, then 42.
    elapsed_time = 8'd100;
    step();
    step();
    elapsed_time = 8'd42;
    wait_pulse(lat, found);
    chk("mid_first_seen", 32'(found), 32'd1);
    chk("mid_first_lat",  32'(lat),   32'd8);
    chk("mid_first_bcd",  32'(bcd),   32'h100);
    wait_pulse(lat, found);
    chk("mid_second_lat", 32'(lat),   32'd10);
    chk("mid_second_bcd", 32'(bcd),   32'h042);
    collect(1'b0, s0, s1, s2, pulses);
    chk("mid_seg_tens", 32'(s1), 32'b1100110);
    chk("mid_seg_hund", 32'(s2), 32'b0000000);

    // Reset at iteration 4 of converting 200.
    elapsed_time = 8'd200;
    for (int i = 0; i < 5; i++) step();
    #1 rst_n = 1'b0;
    #1;
    chk("abort_bcd",   32'(bcd),       32'h000);
    chk("abort_valid", 32'(bcd_valid), 32'h0);
    chk("abort_an",    32'(an),        32'b001);
    chk("abort_seg",   32'(seg),       32'b0111111);
    step();
    step();
    rst_n = 1'b1;
    wait_pulse(lat, found);
    chk("abort_redo_lat", 32'(lat), 32'd10);
    chk("abort_redo_bcd", 32'(bcd), 32'h200);

    // No blanking instance shows leading zeros.
    elapsed_time = 8'd5;
    wait_pulse(lat, found);
    chk("nb_bcd", 32'(bcd_nb), 32'h005);
    collect(1'b1, s0, s1, s2, pulses);
    chk("nb_seg_ones", 32'(s0), 32'b1101101);
    chk("nb_seg_tens", 32'(s1), 32'b0111111);
    chk("nb_seg_hund", 32'(s2), 32'b0111111);

    // Randomized input changes against the model.
    for (int i = 0; i < 600; i++) begin
      step();
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 3) == 0) elapsed_time = 8'($urandom_range(0, 9));
        else elapsed_time = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
